// File: rtl/regfile_mp_scoreboard.sv
// rtl/regfile_mp_scoreboard.sv - multi-port integer register file with write bypass and busy scoreboard
module regfile_mp_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                flush,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    output logic                wr_collide
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    logic wr0_act;
    logic wr1_act;
    logic collide;
    logic wr1_commit;

    // Register 0 is never a write target; port 1 loses a same-address race.
    assign wr0_act    = wr0_en && (wr0_addr != '0);
    assign wr1_act    = wr1_en && (wr1_addr != '0);
    assign collide    = wr0_act && wr1_act && (wr0_addr == wr1_addr);
    assign wr1_commit = wr1_act && !collide;

    // Register storage: reg 0 is only ever cleared, so it reads back as zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wr0_act && (wr0_addr == AW'(i))) begin
                    regs[i] <= wr0_data;
                end else if (wr1_commit && (wr1_addr == AW'(i))) begin
                    regs[i] <= wr1_data;
                end
            end
        end
    end

    // Scoreboard next state: completing writes clear, a younger reserve sets, flush wins over all.
    always_comb begin
        busy_nxt = busy;
        for (int i = 1; i < NREGS; i++) begin
            if ((wr0_act && (wr0_addr == AW'(i))) || (wr1_act && (wr1_addr == AW'(i)))) begin
                busy_nxt[i] = 1'b0;
            end
            if (rsv_en && (rsv_addr == AW'(i))) begin
                busy_nxt[i] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
        if (flush) begin
            busy_nxt = '0;
        end
    end

    // Scoreboard and collision flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy       <= '0;
            wr_collide <= 1'b0;
        end else begin
            busy       <= busy_nxt;
            wr_collide <= collide;
        end
    end

    // Read ports: zero register, then same-cycle bypass (port 0 first), then storage.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit0;
        logic          hit1;

        assign a    = rd_addr[k*AW +: AW];
        assign hit0 = wr0_act && (wr0_addr == a);
        assign hit1 = wr1_act && (wr1_addr == a);

        assign rd_data[k*XLEN +: XLEN] = (a == '0) ? '0       :
                                         hit0      ? wr0_data :
                                         hit1      ? wr1_data :
                                                     regs[a];
        assign rd_busy[k] = busy[a] && !(hit0 || hit1) && (a != '0);
    end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// tb/tb_regfile_mp_scoreboard.sv - scoreboard bench for regfile_mp_scoreboard
module tb_regfile_mp_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr0_en;
    logic [AW-1:0]       wr0_addr;
    logic [XLEN-1:0]     wr0_data;
    logic                wr1_en;
    logic [AW-1:0]       wr1_addr;
    logic [XLEN-1:0]     wr1_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                flush;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_collide;

    regfile_mp_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr0_en     (wr0_en),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr1_en     (wr1_en),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .flush      (flush),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_collide (wr_collide)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                  cyc;
        logic [NRD*XLEN-1:0] data;
        logic [NRD-1:0]      busy;
        logic                coll;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: architectural view of the register file.
    logic [XLEN-1:0] m_reg  [NREGS];
    bit              m_busy [NREGS];
    bit              m_coll;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_no   = 0;

    task automatic cyc(input bit chk, input bit r,
                       input bit w0e, input int w0a, input logic [XLEN-1:0] w0d,
                       input bit w1e, input int w1a, input logic [XLEN-1:0] w1d,
                       input bit re, input int ra, input bit fl,
                       input int a0, input int a1);
        exp_t e;
        int   addrs [NRD];
        @(negedge clk);
        #1;
        rst = r; wr0_en = w0e; wr0_addr = AW'(w0a); wr0_data = w0d;
        wr1_en = w1e; wr1_addr = AW'(w1a); wr1_data = w1d;
        rsv_en = re; rsv_addr = AW'(ra); flush = fl;
        rd_addr = {AW'(a1), AW'(a0)};
        addrs[0] = a0 % NREGS;
        addrs[1] = a1 % NREGS;
        e.cyc  = cyc_no;
        e.coll = m_coll;
        for (int k = 0; k < NRD; k++) begin
            int a = addrs[k];
            bit w0hit = w0e && (w0a % NREGS) == a;
            bit w1hit = w1e && (w1a % NREGS) == a;
            logic [XLEN-1:0] v;
            if (a == 0)      v = '0;
            else if (w0hit)  v = w0d;
            else if (w1hit)  v = w1d;
            else             v = m_reg[a];
            e.data[k*XLEN +: XLEN] = v;
            e.busy[k] = (a != 0) && m_busy[a] && !w0hit && !w1hit;
        end
        if (chk) exp_q.push_back(e);
        cyc_no++;
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < NREGS; i++) begin
                m_reg[i] = '0;
                m_busy[i] = 0;
            end
            m_coll = 0;
        end else begin
            int p0 = w0a % NREGS;
            int p1 = w1a % NREGS;
            int pr = ra % NREGS;
            if (w1e && p1 != 0) m_busy[p1] = 0;
            if (w0e && p0 != 0) m_busy[p0] = 0;
            if (re && pr != 0)  m_busy[pr] = 1;
            if (fl) for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
            if (w1e && p1 != 0) m_reg[p1] = w1d;
            if (w0e && p0 != 0) m_reg[p0] = w0d;
            m_coll = w0e && w1e && p0 != 0 && p0 == p1;
        end
    endtask

    task automatic idle(input int a0, input int a1);
        cyc(1, 1, 0, 0, '0, 0, 0, '0, 0, 0, 0, a0, a1);
    endtask

    // Monitor: outputs are valid every cycle once settled; compare against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (rd_data !== e.data) begin
                    n_fail++;
                    $display("FAIL rd_data cyc=%0d got=%h exp=%h", e.cyc, rd_data, e.data);
                end
                n_checks++;
                if (rd_busy !== e.busy) begin
                    n_fail++;
                    $display("FAIL rd_busy cyc=%0d got=%b exp=%b", e.cyc, rd_busy, e.busy);
                end
                n_checks++;
                if (wr_collide !== e.coll) begin
                    n_fail++;
                    $display("FAIL wr_collide cyc=%0d got=%b exp=%b", e.cyc, wr_collide, e.coll);
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b0; wr0_en = 0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 0; wr1_addr = '0; wr1_data = '0;
        rsv_en = 0; rsv_addr = '0; flush = 0; rd_addr = '0;
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i] = '0;
            m_busy[i] = 0;
        end
        m_coll = 0;

        // Reset; outputs only defined after the first reset edge.
        cyc(0, 0, 0, 0, '0, 0, 0, '0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, '0, 0, 0, '0, 0, 0, 0, 5, 1);

        // Write x5 then reset: value lost.
        cyc(1, 1, 1, 5, 32'hDEADBEEF, 0, 0, '0, 0, 0, 0, 5, 0);
        cyc(1, 0, 0, 0, '0, 0, 0, '0, 0, 0, 0, 5, 5);
        idle(5, 0);

        // Same-cycle bypass and the cycle after.
        cyc(1, 1, 1, 7, 32'h12345678, 0, 0, '0, 0, 0, 0, 7, 0);
        idle(7, 7);

        // x0: writes and reserves ignored.
        cyc(1, 1, 1, 0, 32'hFFFFFFFF, 0, 0, '0, 1, 0, 0, 0, 0);
        idle(0, 0);

        // Collision: port 0 wins, flag for one cycle.
        cyc(1, 1, 1, 3, 32'hAAAA, 1, 3, 32'h5555, 0, 0, 0, 3, 3);
        idle(3, 0);
        idle(3, 0);

        // Scoreboard: reserve, busy, completing write clears and bypasses.
        cyc(1, 1, 0, 0, '0, 0, 0, '0, 1, 10, 0, 10, 0);
        idle(10, 11);
        cyc(1, 1, 0, 0, '0, 1, 10, 32'h42, 0, 0, 0, 10, 10);
        cyc(1, 1, 1, 11, 32'h77, 0, 0, '0, 1, 11, 0, 11, 10);
        idle(11, 10);

        // Flush beats reserve; reset mid-write drops it.
        cyc(1, 1, 0, 0, '0, 0, 0, '0, 1, 4, 0, 4, 0);
        cyc(1, 1, 0, 0, '0, 0, 0, '0, 1, 9, 0, 4, 9);
        cyc(1, 1, 0, 0, '0, 0, 0, '0, 1, 12, 1, 4, 9);
        idle(12, 4);
        cyc(1, 1, 0, 0, '0, 0, 0, '0, 1, 6, 0, 6, 0);
        cyc(1, 0, 1, 6, 32'h1234, 0, 0, '0, 0, 0, 0, 6, 0);
        idle(6, 6);

        // Randomised traffic on a narrow address window to provoke collisions and bypass.
        for (int n = 0; n < 600; n++) begin
            cyc(1, ($urandom_range(0, 99) != 0),
                $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
                ($urandom_range(0, 19) == 0),
                $urandom_range(0, 9), $urandom_range(0, 31));
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
